// File: rtl/traffic_pkg.sv
// Shared types and default constants for the cross-road sensor conditioner.
//   sc_state_e      : debounce / hold FSM state encoding
//   DebCycDefault   : default consecutive samples needed to qualify an edge
//   HoldCycDefault  : default minimum high time after a qualified release
//   CntWDefault     : default width of the arrival counter
package traffic_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StQualOn,
    StPresent,
    StQualOff,
    StHold
  } sc_state_e;

  localparam int unsigned DebCycDefault  = 4;
  localparam int unsigned HoldCycDefault = 8;
  localparam int unsigned CntWDefault    = 8;

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous bit.
//   i_clk   : sampling clock
//   i_rst_n : synchronous active-low reset, clears both flops to 0
//   i_d     : asynchronous input
//   o_q     : synchronized output (second flop)
module bit_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/sensor_conditioner.sv
// Debounces a bouncy loop-detector input into a clean vehicle-presence signal, strobes once per
// qualified arrival and keeps a saturating arrival count.
//   clk          : single clock, rising edge
//   rst_n        : synchronous active-low reset
//   raw_sensor   : asynchronous, bouncy detector input
//   count_clr    : synchronous clear of car_count
//   sensor       : conditioned presence (registered Moore output)
//   arrive_pulse : one-cycle strobe per qualified arrival, coincident with the sensor rise
//   car_count    : saturating count of qualified arrivals
module sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int unsigned DEB_CYC  = DebCycDefault,
  parameter int unsigned HOLD_CYC = HoldCycDefault,
  parameter int unsigned CNT_W    = CntWDefault
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             raw_sensor,
  input  logic             count_clr,
  output logic             sensor,
  output logic             arrive_pulse,
  output logic [CNT_W-1:0] car_count
);

  localparam logic [7:0]       DebLast  = 8'(DEB_CYC - 1);
  localparam logic [7:0]       HoldLast = 8'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] CntMax   = '1;

  logic             w_s;
  sc_state_e        r_state;
  sc_state_e        w_state_d;
  logic [7:0]       r_cnt;
  logic [7:0]       w_cnt_d;
  logic             r_sensor;
  logic             w_sensor_d;
  logic             r_arrive;
  logic             w_arrive_d;
  logic [CNT_W-1:0] r_count;

  // Only the synchronizer ever looks at raw_sensor.
  bit_sync u_bit_sync (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_d     (raw_sensor),
    .o_q     (w_s)
  );

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_arrive_d = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_s) begin
          w_state_d = StQualOn;
          w_cnt_d   = 8'd1;
        end
      end
      StQualOn: begin
        if (!w_s) begin
          w_state_d = StIdle;
        end else if (r_cnt == DebLast) begin
          w_state_d  = StPresent;
          w_arrive_d = 1'b1;
        end else begin
          w_cnt_d = r_cnt + 8'd1;
        end
      end
      StPresent: begin
        if (!w_s) begin
          w_state_d = StQualOff;
          w_cnt_d   = 8'd1;
        end
      end
      StQualOff: begin
        if (w_s) begin
          w_state_d = StPresent;
        end else if (r_cnt == DebLast) begin
          w_state_d = StHold;
          w_cnt_d   = 8'd0;
        end else begin
          w_cnt_d = r_cnt + 8'd1;
        end
      end
      StHold: begin
        // Return to PRESENT without a strobe: the vehicle never left as far as sensor is concerned.
        if (w_s) begin
          w_state_d = StPresent;
        end else if (r_cnt == HoldLast) begin
          w_state_d = StIdle;
        end else begin
          w_cnt_d = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = 8'd0;
      end
    endcase
  end

  // Registered from the next state so sensor tracks the state register with no extra lag.
  assign w_sensor_d = (w_state_d == StPresent) || (w_state_d == StQualOff) ||
                      (w_state_d == StHold);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_cnt    <= 8'd0;
      r_sensor <= 1'b0;
      r_arrive <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_sensor <= w_sensor_d;
      r_arrive <= w_arrive_d;
    end
  end

  // A clear that coincides with a strobe still counts that arrival.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (count_clr) begin
      r_count <= CNT_W'(r_arrive);
    end else if (r_arrive && (r_count != CntMax)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign sensor       = r_sensor;
  assign arrive_pulse = r_arrive;
  assign car_count    = r_count;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed self-checking bench for sensor_conditioner at DEB_CYC=4, HOLD_CYC=8, CNT_W=8.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
module tb_sensor_conditioner;

  logic       clk;
  logic       rst_n;
  logic       raw_sensor;
  logic       count_clr;
  logic       sensor;
  logic       arrive_pulse;
  logic [7:0] car_count;

  int n_tests;
  int n_fail;

  sensor_conditioner #(
    .DEB_CYC  (4),
    .HOLD_CYC (8),
    .CNT_W    (8)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .raw_sensor   (raw_sensor),
    .count_clr    (count_clr),
    .sensor       (sensor),
    .arrive_pulse (arrive_pulse),
    .car_count    (car_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    raw_sensor = 1'b0;
    count_clr  = 1'b0;

    // Reset state
    ticks(3);
    check_eq("rst_sensor", 32'(sensor), 32'd0);
    check_eq("rst_arrive", 32'(arrive_pulse), 32'd0);
    check_eq("rst_count", 32'(car_count), 32'd0);
    rst_n = 1'b1;
    ticks(2);

    // Clean rise: first tick is the capture edge, sensor rises 5 edges later
    raw_sensor = 1'b1;
    ticks(5);
    check_eq("rise_before", 32'(sensor), 32'd0);
    check_eq("rise_arrive_before", 32'(arrive_pulse), 32'd0);
    tick();
    check_eq("rise_sensor", 32'(sensor), 32'd1);
    check_eq("rise_arrive", 32'(arrive_pulse), 32'd1);
    check_eq("rise_count_pre", 32'(car_count), 32'd0);
    tick();
    check_eq("rise_arrive_off", 32'(arrive_pulse), 32'd0);
    check_eq("rise_count", 32'(car_count), 32'd1);
    ticks(13);
    check_eq("rise_held", 32'(sensor), 32'd1);

    // Two-cycle dropout while present must not disturb sensor
    raw_sensor = 1'b0;
    ticks(2);
    raw_sensor = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_eq("dropout_sensor", 32'(sensor), 32'd1);
      check_eq("dropout_arrive", 32'(arrive_pulse), 32'd0);
      tick();
    end

    // Held release: sensor falls 13 edges after capture
    raw_sensor = 1'b0;
    ticks(13);
    check_eq("fall_before", 32'(sensor), 32'd1);
    tick();
    check_eq("fall_sensor", 32'(sensor), 32'd0);
    ticks(5);

    // Short bounce from idle (3 high samples) never qualifies
    raw_sensor = 1'b1;
    ticks(3);
    raw_sensor = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check_eq("bounce_sensor", 32'(sensor), 32'd0);
      check_eq("bounce_arrive", 32'(arrive_pulse), 32'd0);
      tick();
    end
    check_eq("bounce_count", 32'(car_count), 32'd1);

    // Return during HOLD: sensor stays high, no new arrival
    raw_sensor = 1'b1;
    ticks(7);
    check_eq("hold_setup_count", 32'(car_count), 32'd2);
    raw_sensor = 1'b0;
    ticks(8);
    raw_sensor = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check_eq("hold_sensor", 32'(sensor), 32'd1);
      check_eq("hold_arrive", 32'(arrive_pulse), 32'd0);
      tick();
    end
    check_eq("hold_count", 32'(car_count), 32'd2);
    raw_sensor = 1'b0;
    ticks(20);

    // Saturation after 300 arrivals
    for (int i = 0; i < 300; i++) begin
      raw_sensor = 1'b1;
      ticks(10);
      raw_sensor = 1'b0;
      ticks(20);
    end
    check_eq("sat_count", 32'(car_count), 32'd255);

    // Clear coincident with an arrival strobe leaves 1
    raw_sensor = 1'b1;
    ticks(6);
    check_eq("clr_arrive", 32'(arrive_pulse), 32'd1);
    check_eq("clr_sat_hold", 32'(car_count), 32'd255);
    count_clr = 1'b1;
    tick();
    count_clr = 1'b0;
    check_eq("clr_with_arrive", 32'(car_count), 32'd1);

    // Clear alone
    ticks(3);
    count_clr = 1'b1;
    tick();
    count_clr = 1'b0;
    check_eq("clr_alone", 32'(car_count), 32'd0);
    ticks(2);

    // Reset mid-presence with raw held high, then full re-qualification
    check_eq("mid_rst_pre", 32'(sensor), 32'd1);
    rst_n = 1'b0;
    tick();
    check_eq("mid_rst_sensor", 32'(sensor), 32'd0);
    check_eq("mid_rst_count", 32'(car_count), 32'd0);
    rst_n = 1'b1;
    ticks(5);
    check_eq("requal_before", 32'(sensor), 32'd0);
    tick();
    check_eq("requal_sensor", 32'(sensor), 32'd1);
    check_eq("requal_arrive", 32'(arrive_pulse), 32'd1);
    tick();
    check_eq("requal_count", 32'(car_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sensor_conditioner.md
SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

Interface
REQ-001 Parameter DEB_CYC, default 4, is the number of consecutive synchronized samples (2..255) needed to qualify a raw edge.
REQ-002 Parameter HOLD_CYC, default 8, is the minimum number of cycles (1..255) that sensor stays high after a qualified release.
REQ-003 Parameter CNT_W, default 8, is the width of car_count.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous and active-low.
REQ-006 raw_sensor  in  1  asynchronous, bouncy loop-detector input from the cross road.
REQ-007 count_clr  in  1  synchronous clear request for car_count.
REQ-008 sensor  out  1  conditioned vehicle presence, driven to the traffic-light controller's sensor input.
REQ-009 arrive_pulse  out  1  one-cycle strobe, one per qualified arrival.
REQ-010 car_count  out  CNT_W  saturating count of qualified arrivals.

Function
REQ-011 raw_sensor SHALL pass through a 2-flop synchronizer; s denotes the second flop output, and no other logic SHALL sample raw_sensor.
REQ-012 The FSM SHALL have states IDLE, QUAL_ON, PRESENT, QUAL_OFF and HOLD, with an 8-bit counter cnt.
REQ-013 IDLE: if s=1, go to QUAL_ON with cnt=1; else stay.
REQ-014 QUAL_ON: if s=0, go to IDLE (glitch, no side effects); if s=1 and cnt=DEB_CYC-1, go to PRESENT; otherwise cnt+1.
REQ-015 PRESENT: if s=0, go to QUAL_OFF with cnt=1; else stay.
REQ-016 QUAL_OFF: if s=1, go to PRESENT; if s=0 and cnt=DEB_CYC-1, go to HOLD with cnt=0; otherwise cnt+1.
REQ-017 HOLD: if s=1, go to PRESENT with no arrival strobe (same presence); if cnt=HOLD_CYC-1, go to IDLE; otherwise cnt+1.
REQ-018 sensor SHALL be a registered Moore output: 1 in PRESENT, QUAL_OFF and HOLD; 0 in IDLE and QUAL_ON.
REQ-019 Rise latency: sensor SHALL be 1 exactly DEB_CYC+1 edges after the edge at which the synchronizer first flop captures raw_sensor=1 (raw held high).
REQ-020 Fall latency: sensor SHALL be 0 exactly DEB_CYC+HOLD_CYC+1 edges after the first flop captures raw_sensor=0 (raw held low).
REQ-021 arrive_pulse SHALL be 1 for exactly the one cycle following the QUAL_ON->PRESENT transition (coincident with the sensor rise), and 0 otherwise.
REQ-022 car_count SHALL increment on arrive_pulse and saturate at 2^CNT_W-1 with no wrap.
REQ-023 count_clr alone SHALL set car_count to 0 at the next edge; count_clr together with arrive_pulse SHALL set it to 1.
REQ-024 Bounce shorter than DEB_CYC samples SHALL NOT change sensor in any state.

Reset
REQ-025 While rst_n=0 at an edge, the block SHALL load: synchronizer flops 0, state IDLE, cnt 0, sensor 0, arrive_pulse 0, car_count 0.
REQ-026 Reset asserted mid-presence SHALL drop sensor after that edge; with raw still high, a full re-qualification and a new arrive_pulse SHALL follow.

Structure
REQ-027 Package traffic_pkg SHALL hold the FSM state enum typedef and the default DEB_CYC, HOLD_CYC and CNT_W constants.
REQ-028 The synchronizer SHALL be a separate sub-module, bit_sync (2-flop, with sync reset to 0); everything else SHALL be in sensor_conditioner.

Verification (DEB_CYC=4, HOLD_CYC=8, CNT_W=8)
REQ-029 raw 0->1 held 20 cycles -> sensor=1 exactly 5 edges after capture; arrive_pulse high for 1 cycle at that same point; car_count 0->1.
REQ-030 raw high for 3 cycles then low -> sensor stays 0; arrive_pulse stays 0; car_count unchanged.
REQ-031 From PRESENT: a 2-cycle raw dropout -> sensor stays 1; raw low held -> sensor=0 exactly 13 edges after capture.
REQ-032 raw returns high during HOLD -> sensor stays 1 continuously, no arrive_pulse, car_count unchanged.
REQ-033 300 qualified arrivals -> car_count=255; then count_clr in the same cycle as an arrive_pulse -> car_count=1.
REQ-034 rst_n low for 1 cycle in PRESENT with raw held high -> sensor=0 next cycle, then sensor=1 and arrive_pulse again 5 edges after capture post-reset; car_count=1.
